// File: rtl/nn_layer_sequencer.sv
// Layer sequencer for the 26-128-64-32-3 dense classifier: walks every (neuron, input) pair
// of each layer over one shared MAC, ping-pongs activation buffers, then hands off to softmax.
module nn_layer_sequencer #(
    parameter int IN_SIZE_1  = 26,
    parameter int IN_SIZE_2  = 128,
    parameter int IN_SIZE_3  = 64,
    parameter int IN_SIZE_4  = 32,
    parameter int OUT_SIZE_1 = 128,
    parameter int OUT_SIZE_2 = 64,
    parameter int OUT_SIZE_3 = 32,
    parameter int OUT_SIZE_4 = 3,
    parameter int MAC_LAT    = 2,
    parameter int W_ADDR_W   = 14,
    parameter int A_ADDR_W   = 7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic [1:0]          layer,
    output logic [W_ADDR_W-1:0] w_addr,
    output logic [A_ADDR_W-1:0] b_addr,
    output logic [A_ADDR_W-1:0] a_rd_addr,
    output logic [1:0]          rd_src,
    output logic                wr_dst,
    output logic                mac_en,
    output logic                mac_clr,
    output logic                mac_last,
    output logic                relu_en,
    output logic                wb_en,
    output logic [A_ADDR_W-1:0] wb_addr,
    output logic                softmax_start,
    input  logic                softmax_done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_NEXT  = 3'd3;
    localparam logic [2:0] S_SMAX  = 3'd4;
    localparam logic [2:0] S_FIN   = 3'd5;
    localparam int DRAIN_W = $clog2(MAC_LAT + 2);

    logic [2:0]          state;
    logic [1:0]          layer_q;
    logic [A_ADDR_W-1:0] o_cnt, i_cnt, in_last, out_last;
    logic [W_ADDR_W-1:0] w_cnt;
    logic [DRAIN_W-1:0]  drain_cnt;
    logic                smax_first;
    logic                issue, last_i, last_o;

    logic                mac_en_q, mac_clr_q, mac_last_q, mac_dst_q, mac_relu_q;
    logic [A_ADDR_W-1:0] mac_o_q;
    logic [MAC_LAT-1:0]  wb_v, wb_dst, wb_relu;
    logic [A_ADDR_W-1:0] wb_o [MAC_LAT];

    always_comb begin
        in_last  = '0;
        out_last = '0;
        case (layer_q)
            2'd0: begin in_last = A_ADDR_W'(IN_SIZE_1 - 1); out_last = A_ADDR_W'(OUT_SIZE_1 - 1); end
            2'd1: begin in_last = A_ADDR_W'(IN_SIZE_2 - 1); out_last = A_ADDR_W'(OUT_SIZE_2 - 1); end
            2'd2: begin in_last = A_ADDR_W'(IN_SIZE_3 - 1); out_last = A_ADDR_W'(OUT_SIZE_3 - 1); end
            default: begin in_last = A_ADDR_W'(IN_SIZE_4 - 1); out_last = A_ADDR_W'(OUT_SIZE_4 - 1); end
        endcase
    end

    assign issue  = (state == S_RUN);
    assign last_i = (i_cnt == in_last);
    assign last_o = (o_cnt == out_last);

    // w_cnt tracks o*IN+i incrementally instead of multiplying
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            layer_q    <= '0;
            o_cnt      <= '0;
            i_cnt      <= '0;
            w_cnt      <= '0;
            drain_cnt  <= '0;
            smax_first <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    state   <= S_RUN;
                    layer_q <= '0;
                    o_cnt   <= '0;
                    i_cnt   <= '0;
                    w_cnt   <= '0;
                end
                S_RUN: begin
                    w_cnt <= w_cnt + 1'b1;
                    if (last_i) begin
                        i_cnt <= '0;
                        if (last_o) begin
                            state     <= S_DRAIN;
                            o_cnt     <= '0;
                            w_cnt     <= '0;
                            drain_cnt <= '0;
                        end else begin
                            o_cnt <= o_cnt + 1'b1;
                        end
                    end else begin
                        i_cnt <= i_cnt + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == DRAIN_W'(MAC_LAT)) begin
                        if (layer_q == 2'd3) begin
                            state      <= S_SMAX;
                            smax_first <= 1'b1;
                        end else begin
                            state   <= S_NEXT;
                            layer_q <= layer_q + 1'b1;
                        end
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                S_NEXT: state <= S_RUN;
                S_SMAX: begin
                    smax_first <= 1'b0;
                    if (!smax_first && softmax_done) state <= S_FIN;
                end
                S_FIN: begin
                    state   <= S_IDLE;
                    layer_q <= '0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Read latency stage, then MAC_LAT stages carrying the writeback of each neuron
    always_ff @(posedge clk) begin
        if (rst) begin
            mac_en_q   <= 1'b0;
            mac_clr_q  <= 1'b0;
            mac_last_q <= 1'b0;
            mac_dst_q  <= 1'b0;
            mac_relu_q <= 1'b0;
            mac_o_q    <= '0;
            wb_v       <= '0;
            wb_dst     <= '0;
            wb_relu    <= '0;
            for (int unsigned k = 0; k < MAC_LAT; k++) wb_o[k] <= '0;
        end else begin
            mac_en_q   <= issue;
            mac_clr_q  <= issue && (i_cnt == '0);
            mac_last_q <= issue && last_i;
            mac_dst_q  <= layer_q[0];
            mac_relu_q <= (layer_q != 2'd3);
            mac_o_q    <= o_cnt;
            wb_v[0]    <= mac_last_q;
            wb_dst[0]  <= mac_dst_q;
            wb_relu[0] <= mac_relu_q;
            wb_o[0]    <= mac_o_q;
            for (int unsigned k = 1; k < MAC_LAT; k++) begin
                wb_v[k]    <= wb_v[k-1];
                wb_dst[k]  <= wb_dst[k-1];
                wb_relu[k] <= wb_relu[k-1];
                wb_o[k]    <= wb_o[k-1];
            end
        end
    end

    always_comb begin
        rd_src = 2'd0;
        if (issue) begin
            case (layer_q)
                2'd0: rd_src = 2'd0;
                2'd2: rd_src = 2'd2;
                default: rd_src = 2'd1;
            endcase
        end
    end

    assign busy          = (state != S_IDLE);
    assign done          = (state == S_FIN);
    assign layer         = layer_q;
    assign w_addr        = issue ? w_cnt : '0;
    assign b_addr        = issue ? o_cnt : '0;
    assign a_rd_addr     = issue ? i_cnt : '0;
    assign mac_en        = mac_en_q;
    assign mac_clr       = mac_clr_q;
    assign mac_last      = mac_last_q;
    assign wb_en         = wb_v[MAC_LAT-1];
    assign wb_addr       = wb_en ? wb_o[MAC_LAT-1] : '0;
    assign wr_dst        = wb_en & wb_dst[MAC_LAT-1];
    assign relu_en       = wb_en & wb_relu[MAC_LAT-1];
    assign softmax_start = (state == S_SMAX) && smax_first;

endmodule

// File: doc/nn_layer_sequencer.md
# nn_layer_sequencer

Top-level controller for the four-layer dense classifier (26→128→64→32→3). It time-multiplexes one shared MAC/bias/ReLU datapath across all layers. Per cycle it issues weight, bias and activation addresses, drives the MAC accumulate strobes and writeback, and ping-pongs activations between two buffers. After layer 4 it hands the logits to the softmax unit and signals completion.

## Interface
Parameters:
- IN_SIZE_1..IN_SIZE_4, default 26/128/64/32: input width of each dense layer, taken from nn_parameters.
- OUT_SIZE_1..OUT_SIZE_4, default 128/64/32/3: output width of each dense layer, taken from nn_parameters.
- MAC_LAT, default 2: cycles from the MAC's last product to the bias+activation result being valid.
- W_ADDR_W, default 14: weight address width (max IN*OUT = 8192).
- A_ADDR_W, default 7: activation, bias and neuron index width.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: synchronous, active-high reset.
- start, in, 1: begin an inference; sampled only in IDLE.
- busy, out, 1: high in every state except IDLE.
- done, out, 1: one-cycle pulse when the inference is complete.
- layer, out, 2: current layer 0..3; selects the weight/bias ROM.
- w_addr, out, W_ADDR_W: layer-local weight address, o*IN_SIZE + i.
- b_addr, out, A_ADDR_W: bias address, equal to the neuron index o.
- a_rd_addr, out, A_ADDR_W: input activation index i.
- rd_src, out, 2: source buffer, 0=feature, 1=buffer A, 2=buffer B.
- wr_dst, out, 1: destination buffer, 0=buffer A, 1=buffer B.
- mac_en, out, 1: product valid this cycle.
- mac_clr, out, 1: first product of a neuron; the accumulator loads instead of adding.
- mac_last, out, 1: last product of a neuron.
- relu_en, out, 1: apply ReLU; 1 for layers 0–2, 0 for layer 3.
- wb_en, out, 1: write the activation result.
- wb_addr, out, A_ADDR_W: destination neuron index for the write.
- softmax_start, out, 1: one-cycle pulse to the softmax unit.
- softmax_done, in, 1: softmax finished.

## Operation
- FSM states: IDLE, RUN, DRAIN, NEXT, SMAX, FIN.
- IDLE: when start=1, clear the counters, set layer=0, and go to RUN.
- RUN: issue one (o,i) pair per cycle, neuron-major.
  - i increments from 0 to IN-1. At IN-1, i wraps to 0 and o increments.
  - After the pair (OUT-1, IN-1), go to DRAIN.
- DRAIN: wait MAC_LAT+1 cycles for the pipeline to empty, then:
  - go to NEXT if layer<3;
  - go to SMAX if layer=3.
- NEXT: one cycle. Increment layer, then return to RUN. No issue occurs in this cycle.
- SMAX: pulse softmax_start in the first cycle. Wait for softmax_done, which is sampled only from the second SMAX cycle onward. Then go to FIN.
- FIN: pulse done for one cycle, then go to IDLE.
- Buffer routing:

  | Layer | rd_src | wr_dst |
  |---|---|---|
  | 0 | 0 (feature) | 0 (A) |
  | 1 | 1 (A) | 1 (B) |
  | 2 | 2 (B) | 0 (A) |
  | 3 | 1 (A) | 1 (B) |

  Layer 3 logits therefore land in B for the softmax unit.
- Outputs outside their valid windows hold 0: addresses are 0 outside RUN, and strobes are 0.
- start while busy is ignored; there is no queueing.
- Reset (including mid-operation): go to IDLE.
  - All outputs go to 0: busy, done, strobes, layer, addresses, rd_src, wr_dst, softmax_start.
  - Counters are cleared.
  - No writeback is issued after reset.

## Timing
- Memory read latency is 1 cycle. For a pair issued in cycle t:
  - mac_en is asserted in cycle t+1.
  - mac_clr is asserted in t+1 if i=0.
  - mac_last is asserted in t+1 if i=IN-1.
- wb_en and wb_addr=o are asserted in cycle t+1+MAC_LAT, where t is the issue cycle of (o, IN-1).
- wr_dst and relu_en are registered copies aligned with wb_en. They are not the live layer values.
- Reference timeline, with start high in cycle 0 and MAC_LAT=2:
  - Layer 0 RUN: cycles 1–3328. DRAIN: 3329–3331. NEXT: 3332.
  - Layer 1 RUN: 3333–11524. DRAIN: 11525–11527. NEXT: 11528.
  - Layer 2 RUN: 11529–13576. DRAIN: 13577–13579. NEXT: 13580.
  - Layer 3 RUN: 13581–13676. DRAIN: 13677–13679.
  - softmax_start: cycle 13680.
- done is asserted the cycle after the cycle in which softmax_done was sampled high.
- Each layer's last wb_en falls in that layer's final DRAIN cycle. No write overlaps the next layer's first read.

## Test plan
- Reset, then hold idle for 10 cycles → all outputs 0, busy=0.
- Pulse start at cycle 0, with a softmax model that returns done 5 cycles after softmax_start:
  - softmax_start at cycle 13680;
  - done at cycle 13686;
  - exactly 3328+8192+2048+96 = 13664 mac_en pulses;
  - exactly 227 wb_en pulses.
- Layer 0, first neuron:
  - cycles 1–26 give w_addr 0..25 and a_rd_addr 0..25, with b_addr=0;
  - mac_clr at cycle 2, mac_last at cycle 27;
  - wb_en at cycle 29 with wb_addr=0, wr_dst=0, relu_en=1.
- Layer boundaries:
  - layer changes to 1 at cycle 3332;
  - the first RUN cycle of layer 1 has rd_src=1 and w_addr=0;
  - the last layer-3 write has wb_addr=2, wr_dst=1, relu_en=0.
- Pulse start again at cycle 5000 while busy → no effect; the timeline is unchanged.
- Assert rst at cycle 4000 (mid layer 1) → next cycle state is IDLE with all outputs 0. A subsequent start reproduces the reference timeline.
